// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue slice.
package prefetch_pkg;

  localparam int PC_W           = 32;
  localparam int INSTR_W        = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } fetchState_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } queueEntry_t;

  // Word-align a PC by clearing the two byte-offset bits.
  function automatic logic [PC_W-1:0] alignPc(input logic [PC_W-1:0] pc);
    return pc & ~PC_W'(BYTES_PER_WORD - 1);
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Bundle of memory, redirect and decode-side signals of the prefetch queue.
interface instr_prefetch_queue_if
  import prefetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 7
);
  logic                         imem_rd;
  logic [ADDR_W-1:0]            imem_addr;
  logic [BYTE_W-1:0]            imem_rdata;
  logic                         redirect_valid;
  logic [PC_W-1:0]              redirect_pc;
  logic                         out_valid;
  logic                         out_ready;
  logic [INSTR_W-1:0]           out_instr;
  logic [PC_W-1:0]              out_pc;
  logic [$clog2(DEPTH+1)-1:0]   count;
  logic                         misalign_fault;

  // Environment side: memory, execute (redirect) and decode.
  modport master (
    input  imem_rd, imem_addr, out_valid, out_instr, out_pc, count, misalign_fault,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  // Prefetch queue side.
  modport slave (
    output imem_rd, imem_addr, out_valid, out_instr, out_pc, count, misalign_fault,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_prefetch_queue_fifo.sv
// prefetch_fifo: DEPTH-entry queue of {instr, pc} with flush; head is zero when empty.
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  queueEntry_t                pushEntry_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output queueEntry_t                head_o,
  output logic                       headValid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  queueEntry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, wrPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             empty, full, doPush, doPop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign doPop  = pop_i && !empty;
  assign doPush = push_i && (!full || doPop);

  // Flush wins over any simultaneous push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      if (doPush && !doPop)      count_q <= count_q + CNT_W'(1);
      else if (doPop && !doPush) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= pushEntry_i;
  end

  assign head_o      = empty ? '0 : mem_q[rdPtr_q];
  assign headValid_o = !empty;
  assign count_o     = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: byte-serial fetch, little-endian word assembly, redirect flush.
// Build option PREFETCH_ALIGN_CHECK_EN adds the sticky misaligned-redirect fault and HALT state.
module instr_prefetch_queue
  import prefetch_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 7,
  parameter logic [PC_W-1:0] RESET_PC = 32'h0
) (
  input logic                   clk,
  input logic                   rst,
  instr_prefetch_queue_if.slave bus
);
  localparam int         CNT_W     = $clog2(DEPTH + 1);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  fetchState_e          state_q, state_d;
  logic [PC_W-1:0]      fetchPc_q, fetchPc_d, wordPc_q, wordPc_d;
  logic [1:0]           byteIdx_q, byteIdx_d, rdIdx_q, rdIdx_d;
  logic                 rdPending_q, rdPending_d, inFlight_q, inFlight_d;
  logic [3*BYTE_W-1:0]  asm_q, asm_d;
  logic [CNT_W-1:0]     fifoCount;
  logic [CNT_W:0]       reserved;
  logic                 canStart, issue, redirectTaken, haltReq, push, pop, headValid;
  queueEntry_t          pushEntry, headEntry;

`ifdef PREFETCH_ALIGN_CHECK_EN
  logic fault_q;

  assign redirectTaken = bus.redirect_valid && (state_q != HALT);
  assign haltReq       = redirectTaken && (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          fault_q <= 1'b0;
    else if (haltReq) fault_q <= 1'b1;
  end

  assign bus.misalign_fault = fault_q;
`else
  assign redirectTaken      = bus.redirect_valid;
  assign haltReq            = 1'b0;
  assign bus.misalign_fault = 1'b0;
`endif

  // A new word may start only if a queue slot is guaranteed for it on arrival.
  assign reserved = {1'b0, fifoCount} + {{CNT_W{1'b0}}, inFlight_q};
  assign canStart = reserved < (CNT_W + 1)'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirectTaken) begin
      state_d = haltReq ? HALT : FETCH;
    end else begin
      unique case (state_q)
        FETCH:   if (byteIdx_q == 2'd0 && !canStart) state_d = STALL;
        STALL:   if (canStart) state_d = FETCH;
        default: state_d = state_q;
      endcase
    end
  end

  // Reads are held off while reset is asserted and in the redirect cycle itself.
  always_comb begin
    issue = 1'b0;
    if (!rst && !redirectTaken) begin
      unique case (state_q)
        FETCH:   issue = (byteIdx_q != 2'd0) || canStart;
        STALL:   issue = canStart;
        default: issue = 1'b0;
      endcase
    end
    bus.imem_rd   = issue;
    bus.imem_addr = issue ? fetchPc_q[ADDR_W-1:0] + ADDR_W'(byteIdx_q) : '0;
  end

  assign push            = rdPending_q && (rdIdx_q == LAST_BYTE) && !redirectTaken;
  assign pop             = headValid && bus.out_ready;
  assign pushEntry.instr = {bus.imem_rdata, asm_q};
  assign pushEntry.pc    = wordPc_q;

  always_comb begin
    fetchPc_d   = fetchPc_q;
    wordPc_d    = wordPc_q;
    byteIdx_d   = byteIdx_q;
    rdIdx_d     = rdIdx_q;
    rdPending_d = 1'b0;
    inFlight_d  = inFlight_q;
    asm_d       = asm_q;
    if (redirectTaken) begin
      fetchPc_d  = alignPc(bus.redirect_pc);
      byteIdx_d  = 2'd0;
      inFlight_d = 1'b0;
    end else begin
      if (rdPending_q && rdIdx_q != LAST_BYTE) asm_d[{rdIdx_q, 3'b000} +: BYTE_W] = bus.imem_rdata;
      if (push) inFlight_d = 1'b0;
      if (issue) begin
        rdPending_d = 1'b1;
        rdIdx_d     = byteIdx_q;
        byteIdx_d   = byteIdx_q + 2'd1;
        if (byteIdx_q == LAST_BYTE) begin
          wordPc_d   = fetchPc_q;
          fetchPc_d  = fetchPc_q + PC_W'(BYTES_PER_WORD);
          inFlight_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc_q   <= RESET_PC;
      wordPc_q    <= '0;
      byteIdx_q   <= 2'd0;
      rdIdx_q     <= 2'd0;
      rdPending_q <= 1'b0;
      inFlight_q  <= 1'b0;
      asm_q       <= '0;
    end else begin
      fetchPc_q   <= fetchPc_d;
      wordPc_q    <= wordPc_d;
      byteIdx_q   <= byteIdx_d;
      rdIdx_q     <= rdIdx_d;
      rdPending_q <= rdPending_d;
      inFlight_q  <= inFlight_d;
      asm_q       <= asm_d;
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pushEntry_i (pushEntry),
    .pop_i       (pop),
    .flush_i     (redirectTaken),
    .head_o      (headEntry),
    .headValid_o (headValid),
    .count_o     (fifoCount)
  );

  assign bus.out_valid = headValid;
  assign bus.out_instr = headEntry.instr;
  assign bus.out_pc    = headEntry.pc;
  assign bus.count     = fifoCount;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue; exercises PREFETCH_ALIGN_CHECK_EN when defined.
module tb_instr_prefetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic       clk;
  logic       rst;
  logic [7:0] mem [128];
  logic [7:0] memRdata;
  int         checks = 0;
  int         passes = 0;

  instr_prefetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  instr_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory with one cycle of read latency.
  always @(posedge clk) if (bus.imem_rd) memRdata <= mem[bus.imem_addr];
  assign bus.imem_rdata = memRdata;

  // Reference word: byte at the lowest address is the LSB, addresses wrap at 128.
  function automatic logic [31:0] memWord(input logic [31:0] pc);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mem[(pc + 32'(i)) & 32'h7F];
    return w;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    repeat (10) nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_rd !== 1'b0) $display("[TB] FAIL reset_rd: got %b, expected 0", bus.imem_rd); else passes++;
    checks++; if (bus.imem_addr !== 7'h0) $display("[TB] FAIL reset_addr: got %h, expected 0", bus.imem_addr); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b, expected 0", bus.out_valid); else passes++;
    checks++; if (bus.out_instr !== 32'h0) $display("[TB] FAIL reset_instr: got %h, expected 0", bus.out_instr); else passes++;
    checks++; if (bus.out_pc !== 32'h0) $display("[TB] FAIL reset_pc: got %h, expected 0", bus.out_pc); else passes++;
    checks++; if (bus.count !== CNT_W'(0)) $display("[TB] FAIL reset_count: got %0d, expected 0", bus.count); else passes++;
    checks++; if (bus.misalign_fault !== 1'b0) $display("[TB] FAIL reset_fault: got %b, expected 0", bus.misalign_fault); else passes++;
  endtask

  task automatic test_first_word();
    doReset();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc <= 5; cyc++) begin
      if (cyc > 0) nextCycle();
      @(negedge clk);
      if (cyc <= 4) begin
        checks++; if (bus.imem_rd !== 1'b1) $display("[TB] FAIL first_rd c%0d: got %b, expected 1", cyc, bus.imem_rd); else passes++;
        checks++; if (bus.imem_addr !== 7'(cyc)) $display("[TB] FAIL first_addr c%0d: got %h, expected %h", cyc, bus.imem_addr, 7'(cyc)); else passes++;
      end
      if (cyc == 4) begin
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL first_early_valid: got %b, expected 0", bus.out_valid); else passes++;
      end
      if (cyc == 5) begin
        checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL first_valid: got %b, expected 1", bus.out_valid); else passes++;
        checks++; if (bus.out_instr !== 32'h00001020) $display("[TB] FAIL first_instr: got %h, expected 00001020", bus.out_instr); else passes++;
        checks++; if (bus.out_pc !== 32'h0) $display("[TB] FAIL first_pc: got %h, expected 0", bus.out_pc); else passes++;
      end
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic        found;
    int          rdSeen;
    int          got;
    logic [31:0] expPc;
    doReset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      nextCycle();
      @(negedge clk);
      if (bus.count == CNT_W'(DEPTH)) found = 1'b1;
    end
    checks++; if (!found) $display("[TB] FAIL stall_fill: count never reached %0d, got %0d", DEPTH, bus.count); else passes++;
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      @(negedge clk);
      checks++; if (bus.imem_rd !== 1'b0) $display("[TB] FAIL stall_rd: got %b, expected 0", bus.imem_rd); else passes++;
      checks++; if (bus.count !== CNT_W'(DEPTH)) $display("[TB] FAIL stall_count: got %0d, expected %0d", bus.count, DEPTH); else passes++;
    end
    nextCycle();
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_pc !== 32'h0) $display("[TB] FAIL stall_head: got %h, expected 0", bus.out_pc); else passes++;
    nextCycle();
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.count !== CNT_W'(DEPTH - 1)) $display("[TB] FAIL stall_pop_count: got %0d, expected %0d", bus.count, DEPTH - 1); else passes++;
    rdSeen = int'(bus.imem_rd);
    for (int i = 0; i < 12; i++) begin
      nextCycle();
      @(negedge clk);
      rdSeen += int'(bus.imem_rd);
    end
    checks++; if (rdSeen != 4) $display("[TB] FAIL stall_refill_reads: got %0d, expected 4", rdSeen); else passes++;
    checks++; if (bus.count !== CNT_W'(DEPTH)) $display("[TB] FAIL stall_refill_count: got %0d, expected %0d", bus.count, DEPTH); else passes++;
    expPc = 32'h4;
    got = 0;
    for (int i = 0; i < 30 && got < 4; i++) begin
      nextCycle();
      bus.out_ready = 1'b1;
      @(negedge clk);
      if (bus.out_valid) begin
        checks++; if (bus.out_pc !== expPc) $display("[TB] FAIL stall_drain_pc: got %h, expected %h", bus.out_pc, expPc); else passes++;
        checks++; if (bus.out_instr !== memWord(expPc)) $display("[TB] FAIL stall_drain_instr: got %h, expected %h", bus.out_instr, memWord(expPc)); else passes++;
        expPc += 32'h4;
        got++;
      end
    end
    checks++; if (got != 4) $display("[TB] FAIL stall_drain_timeout: drained %0d, expected 4", got); else passes++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_redirect_flush();
    logic found;
    doReset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      nextCycle();
      @(negedge clk);
      if (bus.count == CNT_W'(2) && bus.imem_rd && bus.imem_addr[1:0] == 2'd2) found = 1'b1;
    end
    checks++; if (!found) $display("[TB] FAIL redir_setup: byte 2 at count 2 never seen, count %0d", bus.count); else passes++;
    nextCycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h14;
    for (int k = 1; k <= 6; k++) begin
      nextCycle();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      if (k == 1) begin
        checks++; if (bus.count !== CNT_W'(0)) $display("[TB] FAIL redir_count: got %0d, expected 0", bus.count); else passes++;
        checks++; if (bus.imem_rd !== 1'b1) $display("[TB] FAIL redir_rd: got %b, expected 1", bus.imem_rd); else passes++;
        checks++; if (bus.imem_addr !== 7'h14) $display("[TB] FAIL redir_addr: got %h, expected 14", bus.imem_addr); else passes++;
      end
      if (k < 6) begin
        checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL redir_valid r+%0d: got %b, expected 0", k, bus.out_valid); else passes++;
      end else begin
        checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL redir_revalid: got %b, expected 1", bus.out_valid); else passes++;
        checks++; if (bus.out_pc !== 32'h14) $display("[TB] FAIL redir_pc: got %h, expected 14", bus.out_pc); else passes++;
        checks++; if (bus.out_instr !== memWord(32'h14)) $display("[TB] FAIL redir_instr: got %h, expected %h", bus.out_instr, memWord(32'h14)); else passes++;
      end
    end
  endtask

  task automatic test_addr_wrap();
    logic [31:0] expPc;
    int          got;
    doReset();
    nextCycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h7C;
    for (int k = 0; k <= 4; k++) begin
      nextCycle();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.imem_addr !== 7'(8'h7C + 8'(k))) $display("[TB] FAIL wrap_addr k%0d: got %h, expected %h", k, bus.imem_addr, 7'(8'h7C + 8'(k))); else passes++;
    end
    expPc = 32'h7C;
    got = 0;
    for (int i = 0; i < 30 && got < 2; i++) begin
      nextCycle();
      bus.out_ready = 1'b1;
      @(negedge clk);
      if (bus.out_valid) begin
        checks++; if (bus.out_pc !== expPc) $display("[TB] FAIL wrap_pc: got %h, expected %h", bus.out_pc, expPc); else passes++;
        checks++; if (bus.out_instr !== memWord(expPc)) $display("[TB] FAIL wrap_instr: got %h, expected %h", bus.out_instr, memWord(expPc)); else passes++;
        expPc += 32'h4;
        got++;
      end
    end
    checks++; if (got != 2) $display("[TB] FAIL wrap_timeout: got %0d words, expected 2", got); else passes++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_redirect_pop();
    logic found;
    doReset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      nextCycle();
      @(negedge clk);
      if (bus.count == CNT_W'(1)) found = 1'b1;
    end
    checks++; if (!found) $display("[TB] FAIL rp_setup: count 1 never seen, got %0d", bus.count); else passes++;
    nextCycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    bus.out_ready = 1'b1;
    @(negedge clk);
    nextCycle();
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.count !== CNT_W'(0)) $display("[TB] FAIL rp_count: got %0d, expected 0", bus.count); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL rp_valid: got %b, expected 0", bus.out_valid); else passes++;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      nextCycle();
      @(negedge clk);
      if (bus.out_valid) found = 1'b1;
    end
    checks++; if (bus.out_pc !== 32'h40) $display("[TB] FAIL rp_pc: got %h, expected 40", bus.out_pc); else passes++;
    checks++; if (bus.count !== CNT_W'(1)) $display("[TB] FAIL rp_count_after: got %0d, expected 1", bus.count); else passes++;
  endtask

  // Random decode back-pressure and occasional redirects against an in-order PC scoreboard.
  task automatic test_random_stream();
    logic [31:0] expPc;
    logic        redir;
    int          pops;
    doReset();
    expPc = 32'h0;
    pops = 0;
    for (int i = 0; i < 600; i++) begin
      nextCycle();
      redir = ($urandom_range(0, 39) == 0);
      bus.redirect_valid = redir;
      bus.redirect_pc = $urandom & 32'hFFFF_FFFC;
      bus.out_ready = 1'($urandom_range(0, 1));
      if (redir) expPc = bus.redirect_pc;
      @(negedge clk);
      checks++; if (bus.out_valid !== (bus.count != '0)) $display("[TB] FAIL rnd_valid_vs_count: valid %b, count %0d", bus.out_valid, bus.count); else passes++;
      checks++; if (bus.count > CNT_W'(DEPTH)) $display("[TB] FAIL rnd_count_bound: got %0d, expected <= %0d", bus.count, DEPTH); else passes++;
      if (!bus.out_valid) begin
        checks++; if ({bus.out_instr, bus.out_pc} !== 64'h0) $display("[TB] FAIL rnd_empty_head: got %h/%h, expected 0/0", bus.out_instr, bus.out_pc); else passes++;
      end else if (bus.out_ready && !redir) begin
        checks++; if (bus.out_pc !== expPc) $display("[TB] FAIL rnd_pc: got %h, expected %h", bus.out_pc, expPc); else passes++;
        checks++; if (bus.out_instr !== memWord(expPc)) $display("[TB] FAIL rnd_instr: got %h, expected %h", bus.out_instr, memWord(expPc)); else passes++;
        expPc += 32'h4;
        pops++;
      end
    end
    bus.redirect_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (pops < 40) $display("[TB] FAIL rnd_throughput: got %0d pops, expected >= 40", pops); else passes++;
  endtask

`ifdef PREFETCH_ALIGN_CHECK_EN
  task automatic test_align_check();
    doReset();
    repeat (6) nextCycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h6;
    nextCycle();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.misalign_fault !== 1'b1) $display("[TB] FAIL align_fault: got %b, expected 1", bus.misalign_fault); else passes++;
    checks++; if (bus.count !== CNT_W'(0)) $display("[TB] FAIL align_count: got %0d, expected 0", bus.count); else passes++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.imem_rd !== 1'b0) $display("[TB] FAIL align_halt_rd: got %b, expected 0", bus.imem_rd); else passes++;
      nextCycle();
      @(negedge clk);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8;
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      checks++; if (bus.imem_rd !== 1'b0) $display("[TB] FAIL align_ignore_rd: got %b, expected 0", bus.imem_rd); else passes++;
      checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL align_ignore_valid: got %b, expected 0", bus.out_valid); else passes++;
      checks++; if (bus.misalign_fault !== 1'b1) $display("[TB] FAIL align_sticky: got %b, expected 1", bus.misalign_fault); else passes++;
    end
    doReset();
    @(negedge clk);
    checks++; if (bus.misalign_fault !== 1'b0) $display("[TB] FAIL align_clear: got %b, expected 0", bus.misalign_fault); else passes++;
    checks++; if (bus.imem_rd !== 1'b1) $display("[TB] FAIL align_restart: got %b, expected 1", bus.imem_rd); else passes++;
  endtask
`else
  task automatic test_align_forced();
    logic found;
    doReset();
    nextCycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h16;
    nextCycle();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_addr !== 7'h14) $display("[TB] FAIL forced_addr: got %h, expected 14", bus.imem_addr); else passes++;
    checks++; if (bus.misalign_fault !== 1'b0) $display("[TB] FAIL forced_fault: got %b, expected 0", bus.misalign_fault); else passes++;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      nextCycle();
      @(negedge clk);
      if (bus.out_valid) found = 1'b1;
    end
    checks++; if (bus.out_pc !== 32'h14) $display("[TB] FAIL forced_pc: got %h, expected 14", bus.out_pc); else passes++;
    checks++; if (bus.out_instr !== memWord(32'h14)) $display("[TB] FAIL forced_instr: got %h, expected %h", bus.out_instr, memWord(32'h14)); else passes++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h20;
    mem[1] = 8'h10;
    mem[2] = 8'h00;
    mem[3] = 8'h00;
    $display("[TB] starting instr_prefetch_queue tests");
    test_reset();
    test_first_word();
    test_stall();
    test_redirect_flush();
    test_addr_wrap();
    test_redirect_pop();
    test_random_stream();
`ifdef PREFETCH_ALIGN_CHECK_EN
    test_align_check();
`else
    test_align_forced();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, %0d/%0d checks so far", passes, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
